// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: datapath width, M-extension funct3 encodings,
// and the multiply/divide sequencer states.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_sign_prep.sv
// Operand preparation for the iterative mul/div datapath: decides operand
// signedness from funct3, produces unsigned magnitudes and the sign-fix flags,
// and flags the two division special cases so they can be forced at the end.
import rv32_pkg::*;

module md_sign_prep (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic [XLEN-1:0] o_mag_a,
  output logic [XLEN-1:0] o_mag_b,
  output logic            o_neg_res,
  output logic            o_neg_rem,
  output logic            o_div_zero,
  output logic            o_overflow
);

  logic w_a_signed;
  logic w_b_signed;
  logic w_a_neg;
  logic w_b_neg;

  // Signedness per op; MUL low half is sign-agnostic so it is treated as signed.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (md_op_t'(i_funct3))
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      OP_MULHSU: w_a_signed = 1'b1;
      default: begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
      end
    endcase
  end

  assign w_a_neg = w_a_signed & i_op_a[XLEN-1];
  assign w_b_neg = w_b_signed & i_op_b[XLEN-1];

  // |0x8000_0000| stays 0x8000_0000, which is exact as an unsigned magnitude.
  assign o_mag_a    = w_a_neg ? (~i_op_a + 1'b1) : i_op_a;
  assign o_mag_b    = w_b_neg ? (~i_op_b + 1'b1) : i_op_b;
  assign o_neg_res  = w_a_neg ^ w_b_neg;
  assign o_neg_rem  = w_a_neg;
  assign o_div_zero = (i_op_b == '0);
  assign o_overflow = w_a_signed & w_b_signed & i_funct3[2] &
                      (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) & (i_op_b == '1);

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. One op in flight; fixed latency of
// 33 cycles from the accept edge to the done pulse for every op.
// Handshake: start is taken only in IDLE (including the done cycle, which
// allows back-to-back issue); busy is the stall request from the accept edge
// through the done cycle; done is a one-cycle writeback strobe for result/rd_out.
import rv32_pkg::*;

module mul_div_unit (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic [1:0]      o_dbg_state
);

  md_state_t         r_state;
  logic [CNT_W-1:0]  r_count;
  md_op_t            r_op;
  logic [XLEN-1:0]   r_op_a;
  logic [XLEN-1:0]   r_mag_b;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic              r_div_zero;
  logic              r_ovf;
  logic [4:0]        r_rd;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_neg_res;
  logic              w_neg_rem;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_accept;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_result;

  md_sign_prep u_sign_prep (
    .i_funct3   (funct3),
    .i_op_a     (op_a),
    .i_op_b     (op_b),
    .o_mag_a    (w_mag_a),
    .o_mag_b    (w_mag_b),
    .o_neg_res  (w_neg_res),
    .o_neg_rem  (w_neg_rem),
    .o_div_zero (w_div_zero),
    .o_overflow (w_ovf)
  );

  assign w_accept = (r_state == IDLE) && start && !flush;

  // Shift-add step: add the multiplicand into the high half when the current
  // multiplier bit (product LSB) is set, then shift the whole product right.
  assign w_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_mag_b : '0)};

  // Restoring step: bring the next dividend bit into the 33-bit partial
  // remainder and subtract the divisor if it fits. When it fits the difference
  // is below 2^32, so a 32-bit subtraction is exact.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_mag_b});
  assign w_sub   = w_shift[XLEN-1:0] - r_mag_b;

  assign w_prod_fix = r_neg_res ? (~r_prod + 1'b1) : r_prod;
  assign w_quo_fix  = r_neg_res ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix  = r_neg_rem ? (~r_rem + 1'b1) : r_rem;

  // Final result selection with sign fix and forced division special cases.
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_MUL:                        w_result = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_result = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (r_div_zero)  w_result = '1;
        else if (r_ovf)  w_result = {1'b1, {(XLEN-1){1'b0}}};
        else             w_result = w_quo_fix;
      end
      default: begin
        if (r_div_zero)  w_result = r_op_a;
        else if (r_ovf)  w_result = '0;
        else             w_result = w_rem_fix;
      end
    endcase
  end

  // Sequencer: IDLE -> CALC (32 iterations) -> FINISH -> IDLE; flush aborts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_count <= '0;
              r_state <= CALC;
            end
          end
          CALC: begin
            r_count <= r_count + 1'b1;
            if (r_count == CNT_W'(XLEN-1)) r_state <= FINISH;
          end
          FINISH: begin
            r_result <= w_result;
            r_rd_out <= r_rd;
            r_done   <= 1'b1;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Datapath: capture operands and flags at accept, iterate both engines in CALC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op       <= OP_MUL;
      r_op_a     <= '0;
      r_mag_b    <= '0;
      r_prod     <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd       <= '0;
    end else if (w_accept) begin
      r_op       <= md_op_t'(funct3);
      r_op_a     <= op_a;
      r_mag_b    <= w_mag_b;
      r_prod     <= {{XLEN{1'b0}}, w_mag_a};
      r_quo      <= w_mag_a;
      r_rem      <= '0;
      r_neg_res  <= w_neg_res;
      r_neg_rem  <= w_neg_rem;
      r_div_zero <= w_div_zero;
      r_ovf      <= w_ovf;
      r_rd       <= rd_in;
    end else if (r_state == CALC) begin
      r_prod <= {w_sum, r_prod[XLEN-1:1]};
      r_quo  <= {r_quo[XLEN-2:0], w_ge};
      r_rem  <= w_ge ? w_sub : w_shift[XLEN-1:0];
    end
  end

  assign busy        = (r_state != IDLE) || r_done;
  assign done        = r_done;
  assign result      = r_result;
  assign rd_out      = r_rd_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a table of RV32M vectors with hand-computed
// results and latency, then hand-written flush, held-start, back-to-back and
// mid-operation reset sequences.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  mul_div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flush       (flush),
    .funct3      (funct3),
    .op_a        (op_a),
    .op_b        (op_b),
    .rd_in       (rd_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .rd_out      (rd_out),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns the number of rising edges until done is seen, or -1 if none.
  task automatic wait_done(input int max_cyc, output int lat);
    lat = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Called 1 time unit after an edge with the unit idle; returns just after the accept edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    funct3 = 3'b111; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; rd_in = 5'd31;
  endtask

  initial begin
    int lat;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
    vecs[2]  = '{3'b100, 32'hFFFF_FFEC,  32'd3,         5'd3,  32'hFFFF_FFFA};
    vecs[3]  = '{3'b110, 32'hFFFF_FFEC,  32'd3,         5'd4,  32'hFFFF_FFFE};
    vecs[4]  = '{3'b101, 32'd100,        32'd7,         5'd5,  32'd14};
    vecs[5]  = '{3'b111, 32'd100,        32'd7,         5'd6,  32'd2};
    vecs[6]  = '{3'b100, 32'd5,          32'd0,         5'd7,  32'hFFFF_FFFF};
    vecs[7]  = '{3'b110, 32'd123,        32'd0,         5'd8,  32'd123};
    vecs[8]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'h8000_0000};
    vecs[9]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'd0};
    vecs[10] = '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd11, 32'h4000_0000};
    vecs[11] = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF};
    vecs[12] = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd13, 32'd0};
    vecs[13] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD};
    vecs[14] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 5'd15, 32'd1};
    vecs[15] = '{3'b101, 32'd5,          32'd0,         5'd16, 32'hFFFF_FFFF};
    vecs[16] = '{3'b111, 32'd7,          32'd0,         5'd17, 32'd7};
    vecs[17] = '{3'b000, 32'd12345,      32'd1000,      5'd18, 32'h00BC_5EA8};
    vecs[18] = '{3'b011, 32'h8000_0000,  32'd2,         5'd19, 32'd1};
    vecs[19] = '{3'b110, 32'hFFFF_FFEC,  32'd0,         5'd20, 32'hFFFF_FFEC};

    rst = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = 3'b000; op_a = '0; op_b = '0; rd_in = '0;

    // Reset state
    #12;
    check("reset_busy",   {31'b0, busy},      32'd0);
    check("reset_done",   {31'b0, done},      32'd0);
    check("reset_result", result,             32'd0);
    check("reset_rd",     {27'b0, rd_out},    32'd0);
    check("reset_state",  {30'b0, dbg_state}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
      check($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd1);
      wait_done(40, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_rd", i), {27'b0, rd_out}, {27'b0, vecs[i].rd});
      @(posedge clk); #1;
      check($sformatf("vec%0d_idle", i), {30'b0, busy, done}, 32'd0);
    end

    // Flush during CALC cycle 10: no done, busy drops, result/rd_out held
    issue(3'b000, 32'h111, 32'd3, 5'd9);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy",  {31'b0, busy},      32'd0);
    check("flush_state", {30'b0, dbg_state}, 32'd0);
    wait_done(40, lat);
    check("flush_no_done", 32'(lat), 32'hFFFF_FFFF);
    check("flush_result_held", result, 32'hFFFF_FFEC);
    check("flush_rd_held", {27'b0, rd_out}, 32'd20);
    issue(3'b000, 32'd6, 32'd7, 5'd4);
    wait_done(40, lat);
    check("post_flush_latency", 32'(lat), 32'd33);
    check("post_flush_result", result, 32'd42);
    check("post_flush_rd", {27'b0, rd_out}, 32'd4);
    @(posedge clk); #1;

    // Flush and start together in IDLE: flush wins
    funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd5;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'b0, busy}, 32'd0);
    wait_done(40, lat);
    check("flush_start_no_done", 32'(lat), 32'hFFFF_FFFF);
    check("flush_start_result", result, 32'd42);

    // start held through busy: one done, then start in the done cycle is accepted
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd0; rd_in = 5'd30;
    wait_done(40, lat);
    check("held_latency", 32'(lat), 32'd33);
    check("held_result", result, 32'd15);
    check("held_rd", {27'b0, rd_out}, 32'd2);
    check("held_busy_in_done", {31'b0, busy}, 32'd1);
    funct3 = 3'b101; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("b2b_done_low", {31'b0, done}, 32'd0);
    wait_done(40, lat);
    check("b2b_latency", 32'(lat), 32'd33);
    check("b2b_result", result, 32'd3);
    check("b2b_rd", {27'b0, rd_out}, 32'd3);
    @(posedge clk); #1;

    // Asynchronous reset mid-CALC
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_busy",   {31'b0, busy},      32'd0);
    check("midreset_done",   {31'b0, done},      32'd0);
    check("midreset_result", result,             32'd0);
    check("midreset_rd",     {27'b0, rd_out},    32'd0);
    check("midreset_state",  {30'b0, dbg_state}, 32'd0);
    @(negedge clk); rst = 1'b1;
    wait_done(40, lat);
    check("midreset_no_done", 32'(lat), 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
